// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared fetch front-end types and constants.
// Revision : 1.0
// ============================================================================
package cpu_pkg;

  localparam int PC_W    = 64;
  localparam int INSTR_W = 32;
  localparam logic [PC_W-1:0] PC_INCR = 64'd4;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/pq_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pq_fifo
// Brief    : Synchronous FIFO with flush; flush beats push/pop in a cycle.
// Revision : 1.0
// ============================================================================
module pq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_CW-1:0]  r_count;
  logic             w_full;
  logic             w_empty;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [c_AW-1:0] ptr_inc(input logic [c_AW-1:0] p);
    return (p == c_AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_full    = (r_count == c_CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_pop  = pop && !w_empty && !flush;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_push = push && (!w_full || w_do_pop) && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + c_CW'(w_do_push) - c_CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

  assign pop_data = r_mem[r_rd_ptr];
  assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/instr_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : instr_prefetch_queue
// Brief    : Sequential-PC prefetcher feeding IF/ID; branch redirect flushes.
// Revision : 1.0
// ============================================================================
module instr_prefetch_queue
  import cpu_pkg::*;
#(
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [PC_W-1:0] RESET_PC        = 64'h0
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     redirect_valid,
  input  logic [PC_W-1:0]          redirect_pc,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [PC_W-1:0]          imem_req_addr,
  input  logic                     imem_resp_valid,
  input  logic [INSTR_W-1:0]       imem_resp_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [INSTR_W-1:0]       out_instr,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int c_CNT_W = $clog2(DEPTH) + 1;
  localparam int c_ISS_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int c_OUT_W = $clog2(MAX_OUTSTANDING + 1);

  fetch_state_t       r_state;
  fetch_state_t       w_state_nxt;
  logic [PC_W-1:0]    r_fetch_pc;
  logic [PC_W-1:0]    w_fetch_pc_nxt;
  logic [c_OUT_W-1:0] r_outstanding;
  logic [c_OUT_W-1:0] w_outstanding_nxt;
  logic [c_OUT_W-1:0] r_drop_cnt;
  logic [c_OUT_W-1:0] w_drop_cnt_nxt;
  logic [c_OUT_W-1:0] w_remaining;
  logic [c_CNT_W-1:0] w_count;
  logic [c_ISS_W-1:0] w_issue_cnt;
  logic [PC_W-1:0]    w_resp_pc;
  fetch_entry_t       w_head;
  fetch_entry_t       w_new_entry;
  logic               w_room;
  logic               w_req_fire;
  logic               w_resp_take;
  logic               w_resp_dec;
  logic               w_out_fire;

  // Queued entries plus in-flight requests may never exceed the queue, so
  // every response finds a free slot and is never back-pressured.
  assign w_room = (32'(w_count) + 32'(r_outstanding)) < 32'(DEPTH);

  assign imem_req_valid = !Reset && (r_state == FETCH) && w_room
                       && (r_outstanding < c_OUT_W'(MAX_OUTSTANDING))
                       && (w_issue_cnt < c_ISS_W'(MAX_OUTSTANDING))
                       && !redirect_valid;
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign w_resp_dec  = imem_resp_valid && (r_outstanding != '0);
  assign w_resp_take = w_resp_dec && (r_state == FETCH) && !redirect_valid;
  assign w_remaining = r_outstanding - c_OUT_W'(w_resp_dec);
  assign w_new_entry = '{pc: w_resp_pc, instr: imem_resp_data};

  assign out_valid  = (w_count != '0) && !redirect_valid;
  assign w_out_fire = out_valid && out_ready;
  assign out_pc     = (w_count != '0) ? w_head.pc    : '0;
  assign out_instr  = (w_count != '0) ? w_head.instr : '0;
  assign occupancy  = w_count;

  pq_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_entry_q (
    .clk       (Clk),
    .rst       (Reset),
    .flush     (redirect_valid),
    .push      (w_resp_take),
    .push_data (w_new_entry),
    .pop       (w_out_fire),
    .pop_data  (w_head),
    .count     (w_count)
  );

  // PCs of issued requests, paired in order with their responses.
  pq_fifo #(
    .WIDTH (PC_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_issue_pc_q (
    .clk       (Clk),
    .rst       (Reset),
    .flush     (redirect_valid),
    .push      (w_req_fire),
    .push_data (r_fetch_pc),
    .pop       (w_resp_take),
    .pop_data  (w_resp_pc),
    .count     (w_issue_cnt)
  );

  always_comb begin
    w_state_nxt       = r_state;
    w_fetch_pc_nxt    = r_fetch_pc;
    w_outstanding_nxt = r_outstanding;
    w_drop_cnt_nxt    = r_drop_cnt;
    if (redirect_valid) begin
      // Everything still in flight becomes stale; a response arriving now
      // is already one of them and is dropped on the spot.
      w_fetch_pc_nxt    = redirect_pc;
      w_outstanding_nxt = w_remaining;
      w_drop_cnt_nxt    = w_remaining;
      w_state_nxt       = (w_remaining != '0) ? DRAIN : FETCH;
    end else begin
      unique case (r_state)
        FETCH: begin
          if (w_req_fire) w_fetch_pc_nxt = r_fetch_pc + PC_INCR;
          w_outstanding_nxt = r_outstanding + c_OUT_W'(w_req_fire)
                            - c_OUT_W'(w_resp_take);
        end
        DRAIN: begin
          if (imem_resp_valid && (r_drop_cnt != '0)) begin
            w_drop_cnt_nxt    = r_drop_cnt - 1'b1;
            w_outstanding_nxt = w_remaining;
          end
          if (w_drop_cnt_nxt == '0) w_state_nxt = FETCH;
        end
        default: w_state_nxt = FETCH;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state       <= FETCH;
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_drop_cnt    <= w_drop_cnt_nxt;
    end
  end

endmodule
`default_nettype wire
